// File: rtl/matrix_alu_sequencer_if.sv
// Host command, byte memory and matrix ALU signal bundle
// for the matrix ALU sequencer.
interface matrix_alu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [1:0]        cmd_size;
  logic [7:0]        cmd_scalar;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [ADDR_W-1:0] cmd_base_r;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;

  logic [2:0]        alu_op_code;
  logic [1:0]        alu_matrix_size;
  logic [7:0]        alu_scalar;
  logic [199:0]      alu_matrix_a;
  logic [199:0]      alu_matrix_b;
  logic              alu_start;
  logic              alu_process_done;
  logic              alu_overflow;
  logic [199:0]      alu_result;

  logic              busy;
  logic              done;
  logic              status_overflow;
  logic              status_timeout;
  logic              status_error;

  modport master (
    input  cmd_valid, cmd_op, cmd_size, cmd_scalar,
    input  cmd_base_a, cmd_base_b, cmd_base_r,
    input  mem_rd_data,
    input  alu_process_done, alu_overflow, alu_result,
    output cmd_ready,
    output mem_rd_en, mem_rd_addr,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output alu_op_code, alu_matrix_size, alu_scalar,
    output alu_matrix_a, alu_matrix_b, alu_start,
    output busy, done,
    output status_overflow, status_timeout, status_error
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_size, cmd_scalar,
    output cmd_base_a, cmd_base_b, cmd_base_r,
    output mem_rd_data,
    output alu_process_done, alu_overflow, alu_result,
    input  cmd_ready,
    input  mem_rd_en, mem_rd_addr,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  alu_op_code, alu_matrix_size, alu_scalar,
    input  alu_matrix_a, alu_matrix_b, alu_start,
    input  busy, done,
    input  status_overflow, status_timeout, status_error
  );
endinterface

// File: rtl/matrix_alu_sequencer.sv
// Matrix ALU sequencer: loads operands from byte memory,
// runs the ALU with a timeout and writes the result back.
module matrix_alu_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [2:0]        op_q;
  logic [1:0]        size_q;
  logic [7:0]        scalar_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_r_q;
  logic [199:0]      mat_a;
  logic [199:0]      mat_b;
  logic [199:0]      res_q;
  logic [4:0]        cnt;
  logic [2:0]        row;
  logic [2:0]        col;
  logic [15:0]       tmr;
  logic              pend_v;
  logic              pend_b;
  logic [4:0]        pend_k;
  logic              st_ovf;
  logic              st_tmo;
  logic              st_err;

  logic [2:0]        n_last;
  logic [4:0]        nn;
  logic [4:0]        k_cur;
  logic              need_b;
  logic              st_last;
  logic              accept;
  logic              rd_en;
  logic              wr_en;
  logic              start;
  logic              done_p;
  logic              tmr_hit;
  logic [ADDR_W-1:0] rd_base;

  assign n_last = {1'b0, size_q} + 3'd1;
  assign k_cur  = ({2'b00, row} << 2) + {2'b00, row} + {2'b00, col};
  assign need_b = (op_q == 3'b000) || (op_q == 3'b001) ||
                  (op_q == 3'b110);
  assign accept = (state == S_IDLE) && bus.cmd_valid;
  assign tmr_hit = (tmr == TMO_LAST);
  assign rd_base = (state == S_LOAD_B) ? base_b_q : base_a_q;

  always_comb begin
    nn = 5'd4;
    unique case (size_q)
      2'd0: nn = 5'd4;
      2'd1: nn = 5'd9;
      2'd2: nn = 5'd16;
      2'd3: nn = 5'd25;
    endcase
  end

  // Determinant results are a single scalar in element 0
  assign st_last = (op_q == 3'b101) ? (cnt == 5'd0)
                                    : (cnt == nn - 5'd1);

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    start    = 1'b0;
    done_p   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.cmd_valid)
          state_nx = (bus.cmd_op == 3'b111) ? S_DONE : S_LOAD_A;
      end
      S_LOAD_A: begin
        rd_en = (cnt != nn);
        if (cnt == nn)
          state_nx = need_b ? S_LOAD_B : S_START;
      end
      S_LOAD_B: begin
        rd_en = (cnt != nn);
        if (cnt == nn)
          state_nx = S_START;
      end
      S_START: begin
        start    = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_process_done)
          state_nx = S_STORE;
        else if (tmr_hit)
          state_nx = S_DONE;
      end
      S_STORE: begin
        wr_en = 1'b1;
        if (st_last)
          state_nx = S_DONE;
      end
      S_DONE: begin
        done_p   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      size_q   <= '0;
      scalar_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      mat_a    <= '0;
      mat_b    <= '0;
      res_q    <= '0;
      cnt      <= '0;
      row      <= '0;
      col      <= '0;
      tmr      <= '0;
      pend_v   <= 1'b0;
      pend_b   <= 1'b0;
      pend_k   <= '0;
      st_ovf   <= 1'b0;
      st_tmo   <= 1'b0;
      st_err   <= 1'b0;
    end else begin
      state  <= state_nx;
      pend_v <= rd_en;
      pend_b <= (state == S_LOAD_B);
      pend_k <= k_cur;

      if (state != state_nx) begin
        cnt <= '0;
        row <= '0;
        col <= '0;
      end else if (state == S_LOAD_A || state == S_LOAD_B ||
                   state == S_STORE) begin
        cnt <= cnt + 5'd1;
        if (col == n_last) begin
          col <= '0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end

      tmr <= (state == S_WAIT) ? tmr + 16'd1 : 16'd0;

      // Read data lands one cycle after its strobe
      if (pend_v) begin
        if (pend_b)
          mat_b[{pend_k, 3'b000} +: 8] <= bus.mem_rd_data;
        else
          mat_a[{pend_k, 3'b000} +: 8] <= bus.mem_rd_data;
      end

      if (state == S_WAIT) begin
        if (bus.alu_process_done) begin
          res_q  <= bus.alu_result;
          st_ovf <= bus.alu_overflow;
        end else if (tmr_hit) begin
          st_tmo <= 1'b1;
        end
      end

      if (accept) begin
        op_q     <= bus.cmd_op;
        size_q   <= bus.cmd_size;
        scalar_q <= bus.cmd_scalar;
        base_a_q <= bus.cmd_base_a;
        base_b_q <= bus.cmd_base_b;
        base_r_q <= bus.cmd_base_r;
        mat_a    <= '0;
        mat_b    <= '0;
        st_ovf   <= 1'b0;
        st_tmo   <= 1'b0;
        st_err   <= (bus.cmd_op == 3'b111);
      end
    end
  end

  assign bus.cmd_ready       = (state == S_IDLE);
  assign bus.busy            = (state != S_IDLE);
  assign bus.done            = done_p;
  assign bus.mem_rd_en       = rd_en;
  assign bus.mem_rd_addr     = rd_en ? rd_base + ADDR_W'(cnt) : '0;
  assign bus.mem_wr_en       = wr_en;
  assign bus.mem_wr_addr     = wr_en ? base_r_q + ADDR_W'(cnt) : '0;
  assign bus.mem_wr_data     = wr_en ? res_q[{k_cur, 3'b000} +: 8] : '0;
  assign bus.alu_op_code     = op_q;
  assign bus.alu_matrix_size = size_q;
  assign bus.alu_scalar      = scalar_q;
  assign bus.alu_matrix_a    = mat_a;
  assign bus.alu_matrix_b    = mat_b;
  assign bus.alu_start       = start;
  assign bus.status_overflow = st_ovf;
  assign bus.status_timeout  = st_tmo;
  assign bus.status_error    = st_err;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a behavioural
// memory, a behavioural ALU and a write scoreboard.
module tb_matrix_alu_sequencer;

  logic clk;
  logic rst;

  matrix_alu_sequencer_if #(.ADDR_W(8)) bus ();
  matrix_alu_sequencer_if #(.ADDR_W(8)) bus2 ();

  matrix_alu_sequencer #(.ADDR_W(8), .TIMEOUT(1023)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  matrix_alu_sequencer #(.ADDR_W(8), .TIMEOUT(20)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]   mem [256];
  int           alu_lat;
  logic         armed;
  int           wcnt;
  logic [199:0] tmp_r;
  logic         tmp_o;

  int n_chk, n_fail;
  int cyc, acc_cyc;
  int rd_cnt, wr_cnt, start_cnt, done_cnt, overlap;
  int wr2_cnt, st2_cyc, done2_cyc;
  logic [15:0]  exp_q [$];
  logic [199:0] exp_pk;

  always @(posedge clk) begin
    if (bus.mem_rd_en)
      bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  function automatic void alu_calc(
    input  logic [2:0]   op,
    input  logic [1:0]   sz,
    input  logic [199:0] a,
    input  logic [199:0] b,
    output logic [199:0] r,
    output logic         o
  );
    int n;
    n = int'(sz) + 2;
    r = '0;
    o = 1'b0;
    for (int rr = 0; rr < n; rr++) begin
      for (int cc = 0; cc < n; cc++) begin
        logic [7:0] ea, eb;
        logic [8:0] s;
        ea = a[8*(5*rr+cc) +: 8];
        eb = b[8*(5*rr+cc) +: 8];
        s  = '0;
        case (op)
          3'b000: s = {ea[7], ea} + {eb[7], eb};
          3'b001: s = {ea[7], ea} - {eb[7], eb};
          3'b010: s = {1'b0, a[8*(5*cc+rr) +: 8]};
          3'b011: s = 9'd0 - {ea[7], ea};
          default: s = {ea[7], ea};
        endcase
        r[8*(5*rr+cc) +: 8] = s[7:0];
        if ((op == 3'b000 || op == 3'b001) && (s[8] != s[7]))
          o = 1'b1;
      end
    end
    if (op == 3'b101) begin
      r = '0;
      r[7:0] = a[7:0] * a[55:48] - a[15:8] * a[47:40];
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bus.alu_process_done <= 1'b0;
      armed <= 1'b0;
    end else begin
      bus.alu_process_done <= 1'b0;
      if (bus.alu_start) begin
        alu_calc(bus.alu_op_code, bus.alu_matrix_size,
                 bus.alu_matrix_a, bus.alu_matrix_b, tmp_r, tmp_o);
        bus.alu_result   <= tmp_r;
        bus.alu_overflow <= tmp_o;
        if (alu_lat == 0) begin
          bus.alu_process_done <= 1'b1;
        end else begin
          armed <= 1'b1;
          wcnt  <= alu_lat - 1;
        end
      end else if (armed) begin
        if (wcnt == 0) begin
          bus.alu_process_done <= 1'b1;
          armed <= 1'b0;
        end else begin
          wcnt <= wcnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle step: sample everything on the falling edge
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.alu_start) start_cnt++;
    if (bus.done) done_cnt++;
    if (bus.mem_wr_en) begin
      wr_cnt++;
      chk("wr_expected", 256'(exp_q.size() != 0), 256'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr_data", {bus.mem_wr_addr, bus.mem_wr_data}, e);
      end
    end
    if (bus2.mem_rd_en && bus2.mem_wr_en) overlap++;
    if (bus2.mem_wr_en) wr2_cnt++;
    if (bus2.alu_start) st2_cyc = cyc;
    if (bus2.done && done2_cyc < 0) done2_cyc = cyc;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] sz,
                          input logic [7:0] ba, input logic [7:0] bb,
                          input logic [7:0] br);
    chk("ready_before_cmd", bus.cmd_ready, 1'b1);
    rd_cnt = 0; wr_cnt = 0; start_cnt = 0; done_cnt = 0;
    bus.cmd_op     = op;
    bus.cmd_size   = sz;
    bus.cmd_scalar = 8'd3;
    bus.cmd_base_a = ba;
    bus.cmd_base_b = bb;
    bus.cmd_base_r = br;
    bus.cmd_valid  = 1'b1;
    acc_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    lat = -1;
    for (int i = 0; i < bound; i++) begin
      if (bus.done) begin
        lat = cyc - acc_cyc;
        break;
      end
      tick();
    end
    chk("done_within_bound", 256'(lat >= 0), 256'd1);
    if (lat >= 0) begin
      tick();
      chk("ready_after_done", bus.cmd_ready, 1'b1);
    end
  endtask

  initial begin
    int lat;
    n_chk = 0; n_fail = 0; cyc = 0; overlap = 0;
    wr2_cnt = 0; st2_cyc = -1; done2_cyc = -1;
    rd_cnt = 0; wr_cnt = 0; start_cnt = 0; done_cnt = 0;
    alu_lat = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_size = '0;
    bus.cmd_scalar = '0; bus.cmd_base_a = '0;
    bus.cmd_base_b = '0; bus.cmd_base_r = '0;
    bus.alu_overflow = 1'b0; bus.alu_result = '0;
    bus.mem_rd_data = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 3'b010; bus2.cmd_size = '0;
    bus2.cmd_scalar = '0; bus2.cmd_base_a = 8'h00;
    bus2.cmd_base_b = 8'h00; bus2.cmd_base_r = 8'h50;
    bus2.mem_rd_data = '0; bus2.alu_process_done = 1'b0;
    bus2.alu_overflow = 1'b0; bus2.alu_result = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_flags",
        {bus.cmd_ready, bus.busy, bus.done, bus.mem_rd_en,
         bus.mem_wr_en, bus.alu_start, bus.status_overflow,
         bus.status_timeout, bus.status_error}, 9'b100000000);
    chk("reset_operands", {bus.alu_matrix_a, bus.alu_matrix_b}, 400'd0);
    chk("reset_regs", {bus.alu_op_code, bus.alu_matrix_size,
        bus.alu_scalar, bus.mem_wr_data}, 21'd0);

    // 2x2 add
    for (int i = 0; i < 4; i++) begin
      mem[8'h00 + i] = 8'(i + 1);
      mem[8'h10 + i] = 8'(10 * (i + 1));
      exp_q.push_back({8'(8'h20 + i), 8'(11 * (i + 1))});
    end
    send_cmd(3'b000, 2'd0, 8'h00, 8'h10, 8'h20);
    wait_done(100, lat);
    chk("add_latency", lat, 17);
    chk("add_status", {bus.status_overflow, bus.status_timeout,
        bus.status_error}, 3'b000);
    chk("add_reads", rd_cnt, 8);
    chk("add_writes", wr_cnt, 4);
    chk("add_sb_empty", exp_q.size(), 0);

    // 3x3 transpose
    for (int i = 0; i < 9; i++) mem[8'h40 + i] = 8'(i + 1);
    exp_pk = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        exp_pk[8*(5*r+c) +: 8] = 8'(3*r + c + 1);
        exp_q.push_back({8'(8'h60 + 3*r + c), 8'(3*c + r + 1)});
      end
    end
    send_cmd(3'b010, 2'd1, 8'h40, 8'h80, 8'h60);
    wait_done(100, lat);
    chk("tr_reads", rd_cnt, 9);
    chk("tr_writes", wr_cnt, 9);
    chk("tr_pack_a", bus.alu_matrix_a, exp_pk);
    chk("tr_b_zero", bus.alu_matrix_b, 200'd0);
    chk("tr_sb_empty", exp_q.size(), 0);

    // Determinant with slow ALU
    mem[8'h30] = 8'd3; mem[8'h31] = 8'd1;
    mem[8'h32] = 8'd2; mem[8'h33] = 8'd5;
    alu_lat = 50;
    exp_q.push_back({8'hA0, 8'd13});
    send_cmd(3'b101, 2'd0, 8'h30, 8'h00, 8'hA0);
    wait_done(300, lat);
    alu_lat = 0;
    chk("det_starts", start_cnt, 1);
    chk("det_writes", wr_cnt, 1);
    chk("det_reads", rd_cnt, 4);
    chk("det_sb_empty", exp_q.size(), 0);

    // Illegal op
    send_cmd(3'b111, 2'd2, 8'h00, 8'h00, 8'h00);
    wait_done(10, lat);
    chk("ill_latency", lat, 1);
    chk("ill_status", {bus.status_overflow, bus.status_timeout,
        bus.status_error}, 3'b001);
    chk("ill_strobes", {rd_cnt[7:0], wr_cnt[7:0], start_cnt[7:0]}, 24'd0);

    // Overflow add
    for (int i = 0; i < 4; i++) begin
      mem[8'h00 + i] = 8'd100;
      mem[8'h10 + i] = 8'd100;
      exp_q.push_back({8'(8'h20 + i), 8'd200});
    end
    send_cmd(3'b000, 2'd0, 8'h00, 8'h10, 8'h20);
    wait_done(100, lat);
    chk("ovf_status", {bus.status_overflow, bus.status_timeout,
        bus.status_error}, 3'b100);
    chk("ovf_writes", wr_cnt, 4);

    // Opposite with address wrap on both read and write
    mem[8'hFE] = 8'd1; mem[8'hFF] = 8'd2;
    mem[8'h00] = 8'd3; mem[8'h01] = 8'd4;
    exp_q.push_back({8'hFD, 8'hFF});
    exp_q.push_back({8'hFE, 8'hFE});
    exp_q.push_back({8'hFF, 8'hFD});
    exp_q.push_back({8'h00, 8'hFC});
    send_cmd(3'b011, 2'd0, 8'hFE, 8'h00, 8'hFD);
    wait_done(100, lat);
    chk("wrap_reads", rd_cnt, 4);
    chk("wrap_status", {bus.status_overflow, bus.status_error}, 2'b00);
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Reset during STORE
    for (int i = 0; i < 4; i++) begin
      mem[8'h00 + i] = 8'(i + 1);
      mem[8'h10 + i] = 8'(10 * (i + 1));
    end
    exp_q.push_back({8'h20, 8'd11});
    send_cmd(3'b000, 2'd0, 8'h00, 8'h10, 8'h20);
    for (int i = 0; i < 60; i++) begin
      if (bus.mem_wr_en) break;
      tick();
    end
    chk("rst_store_reached", bus.mem_wr_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wr_stop", bus.mem_wr_en, 1'b0);
    chk("rst_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    repeat (20) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_writes", wr_cnt, 1);
    chk("rst_sb_empty", exp_q.size(), 0);

    // Timeout on the TIMEOUT=20 instance
    chk("to_ready", bus2.cmd_ready, 1'b1);
    bus2.cmd_valid = 1'b1;
    tick();
    bus2.cmd_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done2_cyc >= 0) break;
      tick();
    end
    chk("to_done_seen", 256'(done2_cyc >= 0), 256'd1);
    chk("to_latency", done2_cyc - st2_cyc, 21);
    chk("to_status", {bus2.status_overflow, bus2.status_timeout,
        bus2.status_error}, 3'b010);
    chk("to_writes", wr2_cnt, 0);
    chk("rd_wr_exclusive", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
